// File: rtl/quad_encoder_emu.sv
// rtl/quad_encoder_emu.sv - multi-channel quadrature encoder emulator with external encoder passthrough
// Optional acceleration ramp is enabled by defining QUAD_ACCEL_EN.
module quad_encoder_emu #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int SLOW_DIV    = 5500,
  parameter int FAST_DIV    = 1375,
  parameter int ACCEL_STEPS = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] left,
  input  logic [CHANNELS-1:0] right,
  input  logic [CHANNELS-1:0] ext_a,
  input  logic [CHANNELS-1:0] ext_b,
  output logic [CHANNELS-1:0] enc_a,
  output logic [CHANNELS-1:0] enc_b,
  output logic [CHANNELS-1:0] sel_ext
);

  if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
    $error("quad_encoder_emu: CHANNELS must be 1..4");
  end
  if (SLOW_DIV < 2 || SLOW_DIV >= (1 << DIV_W)) begin : g_bad_slow
    $error("quad_encoder_emu: SLOW_DIV out of range");
  end
  if (FAST_DIV < 2 || FAST_DIV > SLOW_DIV || ACCEL_STEPS < 1) begin : g_bad_accel
    $error("quad_encoder_emu: FAST_DIV/ACCEL_STEPS out of range");
  end

  localparam logic [DIV_W-1:0] SLOW_RELOAD = DIV_W'(SLOW_DIV - 1);
`ifdef QUAD_ACCEL_EN
  localparam logic [DIV_W-1:0] FAST_RELOAD = DIV_W'(FAST_DIV - 1);
  localparam int               ACC_W       = $clog2(ACCEL_STEPS + 1);
  localparam logic [ACC_W-1:0] ACC_MAX     = ACC_W'(ACCEL_STEPS);
`endif

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [1:0]       ph_q, ph_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [1:0]       enc_q, enc_d;
    // external pin pairs are packed {a, b}
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       old_q, old_d;
    logic             fwd, rev, active, step, ext_edge;
    logic [DIV_W-1:0] reload;

    assign fwd    = right[ch] & ~left[ch];
    assign rev    = left[ch] & ~right[ch];
    assign active = fwd | rev;
    assign step   = active && (cnt_q == '0);

`ifdef QUAD_ACCEL_EN
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             last_fwd_q, last_fwd_d;

    always_comb begin
      acc_d      = acc_q;
      last_fwd_d = last_fwd_q;
      if (!active) begin
        acc_d = '0;
      end else begin
        last_fwd_d = fwd;
        if (fwd != last_fwd_q) begin
          acc_d = step ? ACC_W'(1) : '0;
        end else if (step && acc_q != ACC_MAX) begin
          acc_d = acc_q + ACC_W'(1);
        end
      end
      // the reload performed this cycle already sees the updated step count
      reload = (acc_d == ACC_MAX) ? FAST_RELOAD : SLOW_RELOAD;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        acc_q      <= '0;
        last_fwd_q <= 1'b0;
      end else begin
        acc_q      <= acc_d;
        last_fwd_q <= last_fwd_d;
      end
    end
`else
    assign reload = SLOW_RELOAD;
`endif

    always_comb begin
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      sync1_d = {ext_a[ch], ext_b[ch]};
      sync2_d = sync1_q;
      old_d   = sync2_q;
      ext_edge = (sync2_q != old_q);
      if (!active) begin
        cnt_d = reload;
      end else if (step) begin
        cnt_d = reload;
        // Gray sequence 00->01->11->10 forward, reversed for left
        ph_d  = fwd ? {ph_q[0], ~ph_q[1]} : {~ph_q[0], ph_q[1]};
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
      sel_d = step ? 1'b0 : (ext_edge ? 1'b1 : sel_q);
      enc_d = sel_d ? sync2_q : ph_d;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        ph_q    <= 2'b00;
        cnt_q   <= SLOW_RELOAD;
        sel_q   <= 1'b0;
        enc_q   <= 2'b00;
        sync1_q <= 2'b11;
        sync2_q <= 2'b11;
        old_q   <= 2'b11;
      end else begin
        ph_q    <= ph_d;
        cnt_q   <= cnt_d;
        sel_q   <= sel_d;
        enc_q   <= enc_d;
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        old_q   <= old_d;
      end
    end

    assign enc_a[ch]   = enc_q[1];
    assign enc_b[ch]   = enc_q[0];
    assign sel_ext[ch] = sel_q;
  end

endmodule
